hazard_ctl: RTL and testbench
=============================

Name: hazard_ctl

Overview:
- Pipeline interlock controller for the decode stage of the 5-stage pipelined core (IF, ID, EX, MEM, WB).
- Keeps a 3-slot scoreboard of in-flight register writes (EX, MEM, WB).
- Compares the ID instruction's source registers against the scoreboard and drives hold/flush/bubble controls to the PC, IF/ID and ID/EX registers.
- Sequences branch/jump redirects and multi-cycle memory freezes, and counts stall cycles.

Parameters:
- REG_W, 3, register specifier width (8 GPRs; r0 is an ordinary register).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rA  in  REG_W  first read specifier from decode.
- id_rB  in  REG_W  second read specifier from decode.
- id_use_rA  in  1  instruction actually reads rA.
- id_use_rB  in  1  instruction actually reads rB.
- id_wr_en  in  1  instruction writes the register file.
- id_rDest  in  REG_W  destination specifier (r7 when linking).
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- mem_busy  in  1  memory stage not done; whole pipeline frozen.
- pc_hold  out  1  PC must not update.
- if_id_hold  out  1  IF/ID register holds.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads a NOP (valid=0, wr_en=0).
- sb_pending  out  2^REG_W  bitmap of registers with a pending write (any valid slot).
- stall_cnt  out  CNT_W  saturating count of data-hazard stall cycles.

Behaviour:
- State:
  - Slots s1 (EX), s2 (MEM), s3 (WB); each holds {v, reg}.
  - stall_cnt register.
- Reset (rst=0, async): all slot v=0, reg=0, stall_cnt=0.
  - Consequently pc_hold, if_id_hold, if_id_flush, id_ex_bubble and sb_pending are all 0.
- match(r) = OR over valid slots of (slot.reg==r).
- hz = id_valid & ((id_use_rA & match(id_rA)) | (id_use_rB & match(id_rB))).
- Priority, evaluated combinationally each cycle:
  1. mem_busy=1, FREEZE:
     - pc_hold=1, if_id_hold=1; if_id_flush=0, id_ex_bubble=0.
     - Slots and stall_cnt hold.
     - ex_redirect is ignored; EX keeps it asserted until unfrozen.
  2. ex_redirect=1, REDIRECT:
     - if_id_flush=1, id_ex_bubble=1; pc_hold=0, if_id_hold=0.
     - Shift s3<=s2, s2<=s1, s1<={0,0}.
     - The branch itself advances normally, so a JAL/JALR r7 write stays tracked.
  3. hz=1, STALL:
     - pc_hold=1, if_id_hold=1, id_ex_bubble=1.
     - Shift with s1<={0,0}.
     - stall_cnt += 1, saturating at all-ones.
  4. Otherwise, RUN:
     - All controls 0.
     - Shift with s1<={id_valid & id_wr_en, id_rDest}.
- Register file writes at the end of the WB cycle and reads in ID with no internal bypass. A matching s3 therefore stalls.
- Latency: a producer enters EX in cycle t. A dependent instruction sitting in ID at t stalls t, t+1, t+2 and issues at t+3.
- Self-dependence (rA==rDest on the same instruction) never stalls; only slots are compared.
- Duplicate pending writes to one register are legal; the register stays pending until all copies retire.
- Outputs are combinational from slots plus current inputs; no output registers.
- Reset asserted mid-stall or mid-freeze clears all state immediately; the first cycle after release is RUN.

Optional Feature:
- Macro HAZARD_WB_BYPASS_EN.
- Defined: the register file is write-through, so s3 is excluded from match(). A dependent instruction stalls 2 cycles, not 3. sb_pending still includes s3.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared include hazard.vh (same style as ops.vh) holds:
  - slot width/index localparams;
  - the mode encodings FREEZE/REDIRECT/STALL/RUN as 2-bit constants, exported for debug/trace.
- One natural sub-module: hazard_sb_match.
  - Inputs: three {v, reg} slots and one specifier.
  - Output: 1-bit match, with the s3 term gated by HAZARD_WB_BYPASS_EN.
  - Instantiated twice (rA, rB).

Test Plan:
1. Reset, then RUN of id_wr_en=1 id_rDest=3 followed by id_rA=3 id_use_rA=1 -> 3 cycles with pc_hold=if_id_hold=id_ex_bubble=1 (2 with HAZARD_WB_BYPASS_EN); stall_cnt=3 (2); sb_pending bit 3 clears after s3 retires.
2. Producer rDest=5, consumer reads rB=5 but id_use_rB=0 -> no stall; stall_cnt stays 0.
3. Stall in progress on r2, ex_redirect=1 for one cycle -> that cycle if_id_flush=1, id_ex_bubble=1, pc_hold=0; the hazardous ID instruction is discarded; stall_cnt not incremented.
4. JAL enters EX (rDest=7) with ex_redirect=1, next fetched instruction reads r7 -> r7 stays pending; the consumer stalls until s3 retires.
5. mem_busy=1 for 4 cycles during a 3-cycle hazard on r4 -> slots frozen, stall_cnt unchanged during busy; the stall completes after mem_busy drops (3 more hazard cycles).
6. Force stall_cnt to 0xFFFE, hold a hazard for 3 cycles -> 0xFFFF, no wrap. Assert rst=0 asynchronously mid-stall -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_ctl_pkg.sv
// Shared definitions for the decode-stage interlock: scoreboard slot layout
// and the 2-bit control mode encodings (exported for debug/trace).
package hazard_ctl_pkg;
  localparam int NUM_SLOTS = 3;
  localparam int S_EX      = 0;
  localparam int S_MEM     = 1;
  localparam int S_WB      = 2;

  typedef enum logic [1:0] {
    MODE_FREEZE   = 2'd0,
    MODE_REDIRECT = 2'd1,
    MODE_STALL    = 2'd2,
    MODE_RUN      = 2'd3
  } mode_e;
endpackage

// File: rtl/hazard_ctl_if.sv
// Decode/interlock bus: ID instruction info and pipeline events in,
// hold/flush/bubble controls and scoreboard status out.
interface hazard_ctl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic                    id_valid;
  logic [REG_W-1:0]        id_rA;
  logic [REG_W-1:0]        id_rB;
  logic                    id_use_rA;
  logic                    id_use_rB;
  logic                    id_wr_en;
  logic [REG_W-1:0]        id_rDest;
  logic                    ex_redirect;
  logic                    mem_busy;
  logic                    pc_hold;
  logic                    if_id_hold;
  logic                    if_id_flush;
  logic                    id_ex_bubble;
  logic [(1<<REG_W)-1:0]   sb_pending;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, id_rA, id_rB, id_use_rA, id_use_rB, id_wr_en, id_rDest,
           ex_redirect, mem_busy,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, sb_pending, stall_cnt
  );
  modport slave (
    input  id_valid, id_rA, id_rB, id_use_rA, id_use_rB, id_wr_en, id_rDest,
           ex_redirect, mem_busy,
    output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, sb_pending, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl_sb_match.sv
// Compares one source specifier against the in-flight write slots.
// Build option HAZARD_WB_BYPASS_EN: write-through regfile, WB slot not compared.
module hazard_sb_match
  import hazard_ctl_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic [NUM_SLOTS-1:0]            slot_v,
  input  logic [NUM_SLOTS-1:0][REG_W-1:0] slot_reg,
  input  logic [REG_W-1:0]                rs,
  output logic                            hit
);
`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [NUM_SLOTS-1:0] CMP_MASK = 3'b011;
`else
  localparam logic [NUM_SLOTS-1:0] CMP_MASK = 3'b111;
`endif

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      hit = hit | (CMP_MASK[i] & slot_v[i] & (slot_reg[i] == rs));
  end
endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage interlock: 3-slot write scoreboard (EX/MEM/WB), freeze/redirect/
// stall/run sequencing and a saturating stall counter. Option: HAZARD_WB_BYPASS_EN.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctl_if.slave bus
);
  logic [NUM_SLOTS-1:0]            slot_v_q, slot_v_d;
  logic [NUM_SLOTS-1:0][REG_W-1:0] slot_reg_q, slot_reg_d;
  logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;
  logic [1:0][REG_W-1:0]           rs;
  logic [1:0]                      hit;
  logic                            hz;
  mode_e                           mode;

  assign rs = {bus.id_rB, bus.id_rA};

  hazard_sb_match #(.REG_W(REG_W)) u_match [1:0] (
    .slot_v   (slot_v_q),
    .slot_reg (slot_reg_q),
    .rs       (rs),
    .hit      (hit)
  );

  assign hz = bus.id_valid & ((bus.id_use_rA & hit[0]) | (bus.id_use_rB & hit[1]));

  always_comb begin
    if (bus.mem_busy)         mode = MODE_FREEZE;
    else if (bus.ex_redirect) mode = MODE_REDIRECT;
    else if (hz)              mode = MODE_STALL;
    else                      mode = MODE_RUN;
  end

  // Every non-frozen cycle shifts; only RUN lets the ID instruction into EX.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_reg_d  = slot_reg_q;
    stall_cnt_d = stall_cnt_q;
    if (mode != MODE_FREEZE) begin
      slot_v_d   = {slot_v_q[S_MEM], slot_v_q[S_EX], 1'b0};
      slot_reg_d = {slot_reg_q[S_MEM], slot_reg_q[S_EX], {REG_W{1'b0}}};
      if (mode == MODE_RUN) begin
        slot_v_d[S_EX]   = bus.id_valid & bus.id_wr_en;
        slot_reg_d[S_EX] = bus.id_rDest;
      end
    end
    if (mode == MODE_STALL && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v_q    <= '0;
      slot_reg_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_reg_q  <= slot_reg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    bus.pc_hold      = 1'b0;
    bus.if_id_hold   = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        bus.pc_hold    = 1'b1;
        bus.if_id_hold = 1'b1;
      end
      MODE_REDIRECT: begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end
      MODE_STALL: begin
        bus.pc_hold      = 1'b1;
        bus.if_id_hold   = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.sb_pending = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_v_q[i]) bus.sb_pending[slot_reg_q[i]] = 1'b1;
  end

  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus random traffic
// against an age-based model of in-flight writes. Small counter so saturation is reachable.
module tb_hazard_ctl;
  localparam int REG_W = 3;
  localparam int CNT_W = 4;
`ifdef HAZARD_WB_BYPASS_EN
  localparam int MAX_AGE   = 2;
`else
  localparam int MAX_AGE   = 3;
`endif
  localparam int EXP_STALL = MAX_AGE;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();
  hazard_ctl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(hif));

  // A write is tracked by how many cycles it has spent past ID (1=EX .. 3=WB).
  typedef struct { int r; int age; } wr_t;
  wr_t q[$];
  int  m_cnt;
  int  n_assert = 0;
  int  n_fail   = 0;

  function automatic bit m_match(int r);
    foreach (q[i]) if (q[i].r == r && q[i].age <= MAX_AGE) return 1'b1;
    return 1'b0;
  endfunction

  // 0 freeze, 1 redirect, 2 stall, 3 run
  function automatic int m_mode();
    bit hz;
    hz = hif.id_valid && ((hif.id_use_rA && m_match(int'(hif.id_rA))) ||
                          (hif.id_use_rB && m_match(int'(hif.id_rB))));
    if (hif.mem_busy)    return 0;
    if (hif.ex_redirect) return 1;
    if (hz)              return 2;
    return 3;
  endfunction

  function automatic int m_pending();
    int p = 0;
    foreach (q[i]) p |= (1 << q[i].r);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int m = m_mode();
    chk({tag, ".pc_hold"},      32'(hif.pc_hold),      32'(m == 0 || m == 2));
    chk({tag, ".if_id_hold"},   32'(hif.if_id_hold),   32'(m == 0 || m == 2));
    chk({tag, ".if_id_flush"},  32'(hif.if_id_flush),  32'(m == 1));
    chk({tag, ".id_ex_bubble"}, 32'(hif.id_ex_bubble), 32'(m == 1 || m == 2));
    chk({tag, ".sb_pending"},   32'(hif.sb_pending),   32'(m_pending()));
    chk({tag, ".stall_cnt"},    32'(hif.stall_cnt),    32'(m_cnt));
  endtask

  task automatic advance(input bit push, input int r);
    foreach (q[i]) q[i].age++;
    q = q.find(x) with (x.age <= 3);
    if (push) q.push_back('{r: r, age: 1});
  endtask

  // Inputs are already driven; check, clock once, then update the model.
  task automatic step(input string tag);
    int m;
    #1;
    check_all(tag);
    m = m_mode();
    @(posedge clk);
    case (m)
      1: advance(1'b0, 0);
      2: begin advance(1'b0, 0); if (m_cnt < CNT_MAX) m_cnt++; end
      3: advance(hif.id_valid && hif.id_wr_en, int'(hif.id_rDest));
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit wr, input int rd,
                        input int ra, input bit ua, input int rb, input bit ub);
    hif.id_valid  = v;
    hif.id_wr_en  = wr;
    hif.id_rDest  = REG_W'(rd);
    hif.id_rA     = REG_W'(ra);
    hif.id_use_rA = ua;
    hif.id_rB     = REG_W'(rb);
    hif.id_use_rB = ub;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    hif.ex_redirect = 1'b0;
    hif.mem_busy    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    q.delete();
    m_cnt = 0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    q.delete();
    m_cnt = 0;
    #2;
    check_all("por");
    @(negedge clk);
    rst = 1'b1;

    // T1: back-to-back dependency on r3
    set_id(1, 1, 3, 0, 0, 0, 0);        step("t1_prod");
    set_id(1, 0, 0, 3, 1, 0, 0);
    #1 chk("t1_pc_hold", 32'(hif.pc_hold), 32'd1);
    repeat (EXP_STALL) step("t1_stall");
    #1 chk("t1_released", 32'(hif.pc_hold), 32'd0);
    step("t1_issue");
    chk("t1_cnt", 32'(hif.stall_cnt), 32'(EXP_STALL));
    idle();                             step("t1_idle");
    chk("t1_sb_clear", 32'(hif.sb_pending), 32'd0);

    // T2: rB matches but is not used
    do_reset();
    set_id(1, 1, 5, 0, 0, 0, 0);        step("t2_prod");
    set_id(1, 0, 0, 0, 0, 5, 0);
    #1 chk("t2_no_stall", 32'(hif.pc_hold), 32'd0);
    step("t2_cons");
    chk("t2_cnt", 32'(hif.stall_cnt), 32'd0);

    // T3: redirect during a stall on r2
    do_reset();
    set_id(1, 1, 2, 0, 0, 0, 0);        step("t3_prod");
    set_id(1, 0, 0, 0, 0, 2, 1);        step("t3_stall");
    hif.ex_redirect = 1'b1;
    #1 chk("t3_flush", 32'(hif.if_id_flush), 32'd1);
    chk("t3_bubble", 32'(hif.id_ex_bubble), 32'd1);
    chk("t3_pc_hold", 32'(hif.pc_hold), 32'd0);
    step("t3_redirect");
    idle();                             step("t3_after");
    chk("t3_cnt", 32'(hif.stall_cnt), 32'd1);

    // T4: JAL r7 redirects; its link write stays tracked
    do_reset();
    set_id(1, 1, 7, 0, 0, 0, 0);        step("t4_jal");
    set_id(0, 0, 0, 0, 0, 0, 0);
    hif.ex_redirect = 1'b1;
    #1 chk("t4_r7_pending", 32'(hif.sb_pending[7]), 32'd1);
    step("t4_redirect");
    hif.ex_redirect = 1'b0;
    set_id(1, 0, 0, 7, 1, 0, 0);
    repeat (EXP_STALL - 1) step("t4_stall");
    #1 chk("t4_released", 32'(hif.pc_hold), 32'd0);
    step("t4_issue");
    chk("t4_cnt", 32'(hif.stall_cnt), 32'(EXP_STALL - 1));

    // T5: memory freeze over a hazard on r4
    do_reset();
    set_id(1, 1, 4, 0, 0, 0, 0);        step("t5_prod");
    set_id(1, 0, 0, 4, 1, 0, 0);
    hif.mem_busy = 1'b1;
    repeat (4) step("t5_freeze");
    chk("t5_cnt_frozen", 32'(hif.stall_cnt), 32'd0);
    chk("t5_sb_frozen", 32'(hif.sb_pending), 32'h10);
    hif.mem_busy = 1'b0;
    repeat (EXP_STALL) step("t5_stall");
    step("t5_issue");
    chk("t5_cnt", 32'(hif.stall_cnt), 32'(EXP_STALL));

    // T6: counter saturation, then async reset mid-stall
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_id(1, 1, i, 0, 0, 0, 0);      step("t6_prod");
      set_id(1, 0, 0, 0, 0, i, 1);
      repeat (EXP_STALL) step("t6_stall");
    end
    chk("t6_sat", 32'(hif.stall_cnt), 32'(CNT_MAX));
    set_id(1, 1, 1, 0, 0, 0, 0);        step("t6_prod2");
    set_id(1, 0, 0, 1, 1, 0, 0);        step("t6_stall2");
    chk("t6_sat_hold", 32'(hif.stall_cnt), 32'(CNT_MAX));
    rst = 1'b0;
    #1;
    chk("t6_rst_pc_hold", 32'(hif.pc_hold), 32'd0);
    chk("t6_rst_bubble", 32'(hif.id_ex_bubble), 32'd0);
    chk("t6_rst_sb", 32'(hif.sb_pending), 32'd0);
    chk("t6_rst_cnt", 32'(hif.stall_cnt), 32'd0);
    q.delete();
    m_cnt = 0;
    idle();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0, int'($urandom_range(7, 0)),
             int'($urandom_range(7, 0)), $urandom_range(1, 0) != 0,
             int'($urandom_range(7, 0)), $urandom_range(1, 0) != 0);
      hif.ex_redirect = ($urandom_range(7, 0) == 0);
      hif.mem_busy    = ($urandom_range(5, 0) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
